// File: rtl/ps2_drum_key_decoder_pkg.sv
// Shared scancode constants and parser state type for the PS/2 drum-key decoder.
package ps2_drum_key_decoder_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_ERRF  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_t;

  function automatic logic is_error_byte(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_ERRF);
  endfunction

endpackage

// File: rtl/ps2_key_channel.sv
// One tracked drum key: held flag, hit hold-off counter, registered hit/release pulses.
module ps2_key_channel #(
  parameter int HOLDOFF_CYCLES = 500_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic make_match,
  input  logic break_match,
  input  logic clear_all,
  output logic key_held,
  output logic key_hit,
  output logic key_release
);

  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  logic [HW-1:0] holdoff_cnt;

  // Hold-off only gates the hit pulse; a press during hold-off still marks the key held.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_held    <= 1'b0;
      key_hit     <= 1'b0;
      key_release <= 1'b0;
      holdoff_cnt <= '0;
    end else begin
      key_hit     <= 1'b0;
      key_release <= 1'b0;
      if (holdoff_cnt != '0)
        holdoff_cnt <= holdoff_cnt - 1'b1;

      if (clear_all) begin
        key_held <= 1'b0;
      end else if (make_match && !key_held) begin
        key_held <= 1'b1;
        if (holdoff_cnt == '0) begin
          key_hit     <= 1'b1;
          holdoff_cnt <= HW'(HOLDOFF_CYCLES);
        end
      end else if (break_match && key_held) begin
        key_held    <= 1'b0;
        key_release <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_drum_key_decoder.sv
// PS/2 scancode parser (E0/F0 prefixes, BAT, error bytes, prefix timeout) feeding
// NUM_KEYS independent key channels.
module ps2_drum_key_decoder
  import ps2_drum_key_decoder_pkg::*;
#(
  parameter int                      NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*9-1:0]   KEY_CODES      = {9'h02B, 9'h023, 9'h01B, 9'h01C},
  parameter int                      HOLDOFF_CYCLES = 500_000,
  parameter int                      TIMEOUT_CYCLES = 100_000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_hit,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                proto_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  parse_state_t        state, next_state;
  logic [TW-1:0]       timeout_cnt;
  logic                timeout_hit;
  logic                do_make, do_break, ev_ext, clear_all, err_next;
  logic [NUM_KEYS-1:0] code_match;

  // Expiry fires only on an idle cycle; a byte arriving on that cycle wins.
  assign timeout_hit = (state != ST_IDLE) && !rx_valid &&
                       (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= ST_IDLE;
      timeout_cnt <= '0;
      proto_err   <= 1'b0;
    end else begin
      state     <= next_state;
      proto_err <= err_next;
      if (state == ST_IDLE || rx_valid || timeout_hit)
        timeout_cnt <= '0;
      else
        timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    do_make    = 1'b0;
    do_break   = 1'b0;
    ev_ext     = 1'b0;
    clear_all  = 1'b0;
    err_next   = 1'b0;
    if (timeout_hit) begin
      next_state = ST_IDLE;
      err_next   = 1'b1;
    end else if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == SC_EXT)            next_state = ST_EXT;
          else if (rx_data == SC_BREAK)     next_state = ST_BRK;
          else if (rx_data == SC_BAT)       clear_all  = 1'b1;
          else if (is_error_byte(rx_data))  err_next   = 1'b1;
          else                              do_make    = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == SC_BREAK) begin
            next_state = ST_EXT_BRK;
          end else if (rx_data != SC_EXT) begin
            next_state = ST_IDLE;
            if (is_error_byte(rx_data)) begin
              err_next = 1'b1;
            end else begin
              do_make = 1'b1;
              ev_ext  = 1'b1;
            end
          end
        end
        ST_BRK: begin
          if (rx_data == SC_EXT) begin
            next_state = ST_EXT;
            err_next   = 1'b1;
          end else if (rx_data != SC_BREAK) begin
            next_state = ST_IDLE;
            if (is_error_byte(rx_data)) err_next = 1'b1;
            else                        do_break = 1'b1;
          end
        end
        ST_EXT_BRK: begin
          next_state = ST_IDLE;
          if (rx_data == SC_EXT || rx_data == SC_BREAK || is_error_byte(rx_data)) begin
            err_next = 1'b1;
          end else begin
            do_break = 1'b1;
            ev_ext   = 1'b1;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Every channel whose code matches fires, so duplicate codes drive several channels.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    assign code_match[i] = (KEY_CODES[9*i +: 9] == {ev_ext, rx_data});

    ps2_key_channel #(
      .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_chan (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .make_match (do_make & code_match[i]),
      .break_match(do_break & code_match[i]),
      .clear_all  (clear_all),
      .key_held   (key_held[i]),
      .key_hit    (key_hit[i]),
      .key_release(key_release[i])
    );
  end

endmodule

// File: tb/tb_ps2_drum_key_decoder.sv
// Self-checking bench: directed vector table, hand-written hold-off/timeout sequences,
// and randomized byte streams compared against a prefix-flag reference model.
module tb_ps2_drum_key_decoder;

  localparam int          NK    = 4;
  localparam int          HOLD  = 20;
  localparam int          TMO   = 50;
  localparam logic [35:0] CODES = {9'h02B, 9'h023, 9'h175, 9'h01C};

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [NK-1:0] key_held, key_hit, key_release;
  logic          proto_err;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_drum_key_decoder #(
    .NUM_KEYS      (NK),
    .KEY_CODES     (CODES),
    .HOLDOFF_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .key_held   (key_held),
    .key_hit    (key_hit),
    .key_release(key_release),
    .proto_err  (proto_err)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: prefix flags, cycle-stamped last hit per channel.
  logic [35:0]   codes_v = CODES;
  bit            m_ext, m_brk;
  int            m_idle;
  logic [NK-1:0] m_held;
  longint        m_last[NK];
  longint        cyc = 0;
  logic [NK-1:0] e_hit, e_rel;
  bit            e_err;

  task automatic modelMake(input bit e, input logic [7:0] c);
    for (int i = 0; i < NK; i++) begin
      if (codes_v[9*i +: 9] == {e, c} && !m_held[i]) begin
        m_held[i] = 1'b1;
        if (cyc - m_last[i] > HOLD) begin
          e_hit[i]  = 1'b1;
          m_last[i] = cyc;
        end
      end
    end
  endtask

  task automatic modelBreak(input bit e, input logic [7:0] c);
    for (int i = 0; i < NK; i++) begin
      if (codes_v[9*i +: 9] == {e, c} && m_held[i]) begin
        m_held[i] = 1'b0;
        e_rel[i]  = 1'b1;
      end
    end
  endtask

  task automatic modelStep(input bit r, input bit v, input logic [7:0] d);
    bit pending;
    cyc++;
    e_hit = '0;
    e_rel = '0;
    e_err = 1'b0;
    if (r) begin
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_idle = 0;
      m_held = '0;
      for (int i = 0; i < NK; i++) m_last[i] = -1000;
    end else if (v) begin
      m_idle  = 0;
      pending = m_ext | m_brk;
      if (d == 8'h00 || d == 8'hFF) begin
        e_err = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else if (d == 8'hE0) begin
        if (m_brk && !m_ext) begin
          e_err = 1'b1;
          m_ext = 1'b1;
          m_brk = 1'b0;
        end else if (m_brk && m_ext) begin
          e_err = 1'b1;
          m_ext = 1'b0;
          m_brk = 1'b0;
        end else begin
          m_ext = 1'b1;
        end
      end else if (d == 8'hF0) begin
        if (m_ext && m_brk) begin
          e_err = 1'b1;
          m_ext = 1'b0;
          m_brk = 1'b0;
        end else begin
          m_brk = 1'b1;
        end
      end else if (d == 8'hAA && !pending) begin
        m_held = '0;
      end else begin
        if (m_brk) modelBreak(m_ext, d);
        else       modelMake(m_ext, d);
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle == TMO) begin
        e_err  = 1'b1;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_idle = 0;
      end
    end
  endtask

  // One clock cycle: drive inputs, take the edge, settle, advance the model.
  task automatic applyStimulus(input bit r, input bit v, input logic [7:0] d);
    reset    = r;
    rx_valid = v;
    rx_data  = d;
    @(posedge CLOCK_50);
    #1;
    modelStep(r, v, d);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic checkAll(input string tag, input logic [3:0] h, input logic [3:0] hi,
                          input logic [3:0] r, input bit e);
    checkOutput({tag, ".held"},    key_held,           h);
    checkOutput({tag, ".hit"},     key_hit,            hi);
    checkOutput({tag, ".release"}, key_release,        r);
    checkOutput({tag, ".err"},     {3'b000, proto_err}, {3'b000, e});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  typedef struct {
    int         pre_idle;
    bit         rst;
    bit         valid;
    logic [7:0] data;
    logic [3:0] held;
    logic [3:0] hit;
    logic [3:0] rel;
    bit         err;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input int p, input bit r, input bit v, input logic [7:0] d,
                                 input logic [3:0] h, input logic [3:0] hi,
                                 input logic [3:0] rl, input bit e);
    vec_t t;
    t.pre_idle = p; t.rst = r; t.valid = v; t.data = d;
    t.held = h; t.hit = hi; t.rel = rl; t.err = e;
    vecs.push_back(t);
  endfunction

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // reset state
    addVec(0, 1, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 0);
    addVec(0, 1, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 0);
    // press / release
    addVec(0, 0, 1, 8'h1C, 4'b0001, 4'b0001, 4'b0000, 0);
    addVec(0, 0, 0, 8'h00, 4'b0001, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'hF0, 4'b0001, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'h1C, 4'b0000, 4'b0000, 4'b0001, 0);
    addVec(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 0);
    // typematic repeat
    addVec(25, 0, 1, 8'h1C, 4'b0001, 4'b0001, 4'b0000, 0);
    addVec(0, 0, 1, 8'h1C, 4'b0001, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'h1C, 4'b0001, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'hF0, 4'b0001, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'h1C, 4'b0000, 4'b0000, 4'b0001, 0);
    // extended key on ch1
    addVec(0, 0, 1, 8'hE0, 4'b0000, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'h75, 4'b0010, 4'b0010, 4'b0000, 0);
    addVec(0, 0, 1, 8'h75, 4'b0010, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'hE0, 4'b0010, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'hF0, 4'b0010, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'h75, 4'b0000, 4'b0000, 4'b0010, 0);
    // unmatched break
    addVec(0, 0, 1, 8'hF0, 4'b0000, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'h5A, 4'b0000, 4'b0000, 4'b0000, 0);
    // BAT clears, error bytes, reset mid-prefix
    addVec(25, 0, 1, 8'h1C, 4'b0001, 4'b0001, 4'b0000, 0);
    addVec(0, 0, 1, 8'h23, 4'b0101, 4'b0100, 4'b0000, 0);
    addVec(0, 0, 1, 8'hAA, 4'b0000, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 1);
    addVec(0, 0, 1, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1);
    addVec(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'hE0, 4'b0000, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'hF0, 4'b0000, 4'b0000, 4'b0000, 0);
    addVec(0, 1, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'h2B, 4'b1000, 4'b1000, 4'b0000, 0);
    // BRK then E0 is an error that lands in EXT
    addVec(0, 0, 1, 8'hF0, 4'b1000, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'hE0, 4'b1000, 4'b0000, 4'b0000, 1);
    addVec(0, 0, 1, 8'h75, 4'b1010, 4'b0010, 4'b0000, 0);
    // repeated F0 stays in BRK
    addVec(0, 0, 1, 8'hF0, 4'b1010, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'hF0, 4'b1010, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'h2B, 4'b0010, 4'b0000, 4'b1000, 0);
    // EXT_BRK then F0 is an error back to IDLE
    addVec(0, 0, 1, 8'hE0, 4'b0010, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'hF0, 4'b0010, 4'b0000, 4'b0000, 0);
    addVec(0, 0, 1, 8'hF0, 4'b0010, 4'b0000, 4'b0000, 1);
    addVec(0, 0, 1, 8'h75, 4'b0010, 4'b0000, 4'b0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      idle(vecs[i].pre_idle);
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data);
      checkAll($sformatf("vec%0d", i), vecs[i].held, vecs[i].hit, vecs[i].rel, vecs[i].err);
    end

    // prefix timeout at exactly TMO idle cycles, then FSM is back in IDLE
    applyStimulus(1'b0, 1'b1, 8'hF0);
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput($sformatf("timeout.err@%0d", k), {3'b000, proto_err},
                  (k == TMO) ? 4'b0001 : 4'b0000);
    end
    applyStimulus(1'b0, 1'b1, 8'h23);
    checkAll("timeout.after", 4'b0110, 4'b0100, 4'b0000, 0);

    // byte arriving on the would-be expiry cycle is processed instead
    applyStimulus(1'b0, 1'b1, 8'hF0);
    for (int k = 1; k < TMO; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput($sformatf("expiry.err@%0d", k), {3'b000, proto_err}, 4'b0000);
    end
    applyStimulus(1'b0, 1'b1, 8'h23);
    checkAll("expiry.byte", 4'b0010, 4'b0000, 4'b0100, 0);

    // hit hold-off on ch0
    applyStimulus(1'b0, 1'b1, 8'h1C);
    checkAll("holdoff.first", 4'b0011, 4'b0001, 4'b0000, 0);
    applyStimulus(1'b0, 1'b1, 8'hF0);
    applyStimulus(1'b0, 1'b1, 8'h1C);
    checkAll("holdoff.rel1", 4'b0010, 4'b0000, 4'b0001, 0);
    applyStimulus(1'b0, 1'b1, 8'h1C);
    checkAll("holdoff.suppressed", 4'b0011, 4'b0000, 4'b0000, 0);
    applyStimulus(1'b0, 1'b1, 8'hF0);
    applyStimulus(1'b0, 1'b1, 8'h1C);
    checkAll("holdoff.rel2", 4'b0010, 4'b0000, 4'b0001, 0);
    idle(25);
    applyStimulus(1'b0, 1'b1, 8'h1C);
    checkAll("holdoff.again", 4'b0011, 4'b0001, 4'b0000, 0);

    // randomized traffic against the reference model
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkAll("rand.reset", e_hit | m_held, e_hit, e_rel, e_err);
    for (int n = 0; n < 400; n++) begin
      int         g, gap, sel;
      logic [7:0] b;
      logic [7:0] keys[5];
      keys = '{8'h1C, 8'h23, 8'h2B, 8'h75, 8'h5A};
      g   = $urandom_range(0, 99);
      gap = (g < 70) ? $urandom_range(0, 3) : (g < 90) ? $urandom_range(15, 25)
                                                       : $urandom_range(45, 55);
      for (int k = 0; k < gap; k++) begin
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkAll("rand.idle", m_held, e_hit, e_rel, e_err);
      end
      sel = $urandom_range(0, 99);
      if (sel < 20)      b = 8'hE0;
      else if (sel < 40) b = 8'hF0;
      else if (sel < 85) b = keys[$urandom_range(0, 4)];
      else if (sel < 90) b = 8'hAA;
      else if (sel < 95) b = 8'h00;
      else               b = 8'hFF;
      if ($urandom_range(0, 149) == 0) applyStimulus(1'b1, 1'b0, 8'h00);
      else                             applyStimulus(1'b0, 1'b1, b);
      checkAll($sformatf("rand%0d", n), m_held, e_hit, e_rel, e_err);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
